rv32i_instr_enc: RTL and testbench

- Streaming RV32I instruction encoder, the inverse of the core's immediate decode path.
- Accepts decomposed fields (opcode, rd, funct3, rs1, rs2, 32-bit immediate value, imm_type_e) on a valid/ready input.
- Range- and alignment-checks the immediate, then packs a 32-bit instruction word into an output FIFO drained by a valid/ready output.
- Used by the debug program-buffer and the self-test instruction injector.

---
 rtl/rv32i_instr_enc_if.sv | 46 ++++
 rtl/rv32i_instr_enc.sv | 110 +++++++++++
 tb/tb_rv32i_instr_enc.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_instr_enc_if.sv
// Shared immediate-format type and the request/response bundle of the
// RV32I instruction encoder.
package rv32i_instr_enc_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;
endpackage

// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The request side (in_*) is driven by the producer, and the
// encoder answers with in_ready_o. The response side (out_*) is driven by the
// encoder, and the consumer answers with out_ready_i. A valid response keeps
// its payload stable until it is taken.
interface rv32i_instr_enc_if;
  import rv32i_instr_enc_pkg::*;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  in_opcode_i;
  logic [4:0]  in_rd_i;
  logic [2:0]  in_funct3_i;
  logic [4:0]  in_rs1_i;
  logic [4:0]  in_rs2_i;
  logic [31:0] in_imm_i;
  imm_type_e   in_imm_type_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_err_o;

  modport master (
    output in_valid_i, in_opcode_i, in_rd_i, in_funct3_i, in_rs1_i,
           in_rs2_i, in_imm_i, in_imm_type_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_err_o
  );

  modport slave (
    input  in_valid_i, in_opcode_i, in_rd_i, in_funct3_i, in_rs1_i,
           in_rs2_i, in_imm_i, in_imm_type_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_err_o
  );
endinterface

// File: rtl/rv32i_instr_enc.sv
// Streaming RV32I instruction encoder: it checks the immediate against the
// selected format, packs the instruction word and queues it in a small FIFO.
module rv32i_instr_enc
  import rv32i_instr_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter bit DROP_ERR   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rv32i_instr_enc_if.slave bus,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] enc_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [OW-1:0] occ_q;
  logic [32:0]   mem_q [FIFO_DEPTH];

  logic [31:0] imm;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        accept;
  logic        push;
  logic        pop;

  assign imm = bus.in_imm_i;

  // Format check and bit packing of the current request; unused fields stay zero.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (bus.in_imm_type_i)
      IMM_I: begin
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
        enc_word = {imm[11:0], bus.in_rs1_i, bus.in_funct3_i, bus.in_rd_i,
                    bus.in_opcode_i};
      end
      IMM_S: begin
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
        enc_word = {imm[11:5], bus.in_rs2_i, bus.in_rs1_i, bus.in_funct3_i,
                    imm[4:0], bus.in_opcode_i};
      end
      IMM_B: begin
        enc_err  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
        enc_word = {imm[12], imm[10:5], bus.in_rs2_i, bus.in_rs1_i,
                    bus.in_funct3_i, imm[4:1], imm[11], bus.in_opcode_i};
      end
      IMM_U: begin
        enc_err  = |imm[11:0];
        enc_word = {imm[31:12], bus.in_rd_i, bus.in_opcode_i};
      end
      IMM_J: begin
        enc_err  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd_i,
                    bus.in_opcode_i};
      end
      default: begin
        enc_err  = 1'b1;
        enc_word = '0;
      end
    endcase
  end

  // No pop-to-push pass-through: a full FIFO refuses requests even if the
  // consumer is draining in the same cycle.
  assign bus.in_ready_o  = !rst_i && (occ_q < OW'(FIFO_DEPTH));
  assign accept          = bus.in_valid_i && bus.in_ready_o;
  assign push            = accept && (!enc_err || !DROP_ERR);
  assign bus.out_valid_o = (occ_q != '0);
  assign pop             = bus.out_valid_o && bus.out_ready_i;

  // Head entry is masked to zero when the FIFO is empty so no stale word shows.
  assign bus.out_instr_o = bus.out_valid_o ? mem_q[rd_ptr_q][31:0] : '0;
  assign bus.out_err_o   = bus.out_valid_o ? mem_q[rd_ptr_q][32] : 1'b0;

  // Pointers, occupancy, error pulse and saturating statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      err_pulse_o <= 1'b0;
      enc_count_o <= '0;
      err_count_o <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      occ_q <= occ_q + 1'b1;
      else if (!push && pop) occ_q <= occ_q - 1'b1;
      err_pulse_o <= accept && enc_err;
      if (push && !(&enc_count_o))
        enc_count_o <= enc_count_o + 1'b1;
      if (accept && enc_err && !(&err_count_o))
        err_count_o <= err_count_o + 1'b1;
    end
  end

  // Entry storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {enc_err, enc_word};
  end

endmodule

// File: tb/tb_rv32i_instr_enc.sv
// Bench for rv32i_instr_enc: a drop-on-error instance (depth 2, 16-bit
// counters) and a keep-on-error instance (depth 4, 3-bit counters) share the
// same stimulus and are each compared every cycle with a queue-based model.
module tb_rv32i_instr_enc;
  import rv32i_instr_enc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus variables ----------------
  logic        in_valid;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [2:0]  in_f3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  imm_type_e   in_type;
  logic        out_ready;

  rv32i_instr_enc_if if0 ();
  rv32i_instr_enc_if if1 ();

  assign if0.in_valid_i = in_valid;  assign if1.in_valid_i = in_valid;
  assign if0.in_opcode_i = in_op;    assign if1.in_opcode_i = in_op;
  assign if0.in_rd_i = in_rd;        assign if1.in_rd_i = in_rd;
  assign if0.in_funct3_i = in_f3;    assign if1.in_funct3_i = in_f3;
  assign if0.in_rs1_i = in_rs1;      assign if1.in_rs1_i = in_rs1;
  assign if0.in_rs2_i = in_rs2;      assign if1.in_rs2_i = in_rs2;
  assign if0.in_imm_i = in_imm;      assign if1.in_imm_i = in_imm;
  assign if0.in_imm_type_i = in_type; assign if1.in_imm_type_i = in_type;
  assign if0.out_ready_i = out_ready; assign if1.out_ready_i = out_ready;

  logic        pulse0, pulse1;
  logic [15:0] enc0, errc0;
  logic [2:0]  enc1, errc1;

  rv32i_instr_enc #(.FIFO_DEPTH(2), .DROP_ERR(1'b1), .CNT_W(16)) dut_drop (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave),
    .err_pulse_o(pulse0), .enc_count_o(enc0), .err_count_o(errc0)
  );

  rv32i_instr_enc #(.FIFO_DEPTH(4), .DROP_ERR(1'b0), .CNT_W(3)) dut_keep (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave),
    .err_pulse_o(pulse1), .enc_count_o(enc1), .err_count_o(errc1)
  );

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q [2][$];
  int          m_enc [2];
  int          m_err [2];
  bit          m_pulse [2];
  int          depth [2] = '{2, 4};
  bit          drop  [2] = '{1'b1, 1'b0};
  int          cmax  [2] = '{65535, 7};

  // {error, word} straight from the format rules: signed ranges, alignment
  // and field placement by shifting and masking.
  function automatic logic [32:0] model_encode(
    input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
    input imm_type_e t);
    int          s;
    bit          err;
    logic [31:0] w;
    s   = int'(imm);
    err = 1'b0;
    w   = 32'd0;
    case (t)
      IMM_I: begin
        err = (s < -2048) || (s > 2047);
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (32'(rd) << 7) | 32'(op);
      end
      IMM_S: begin
        err = (s < -2048) || (s > 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      end
      IMM_B: begin
        err = (s < -4096) || (s > 4095) || ((imm & 32'd1) != 0);
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      end
      IMM_U: begin
        err = (imm % 32'd4096) != 0;
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      IMM_J: begin
        err = (s < -1048576) || (s > 1048575) || ((imm & 32'd1) != 0);
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
            (32'(rd) << 7) | 32'(op);
      end
      default: begin
        err = 1'b1;
        w = 32'd0;
      end
    endcase
    return {err, w};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic rdy, input logic vld,
                           input logic [31:0] instr, input logic err,
                           input logic pls, input logic [31:0] encc,
                           input logic [31:0] errc);
    logic [32:0] head;
    bit          ev;
    ev   = exp_q[d].size() > 0;
    head = ev ? exp_q[d][0] : 33'd0;
    chk($sformatf("d%0d.in_ready", d), 32'(rdy), 32'(!rst && (exp_q[d].size() < depth[d])));
    chk($sformatf("d%0d.out_valid", d), 32'(vld), 32'(ev));
    chk($sformatf("d%0d.out_instr", d), instr, head[31:0]);
    chk($sformatf("d%0d.out_err", d), 32'(err), 32'(head[32]));
    chk($sformatf("d%0d.err_pulse", d), 32'(pls), 32'(m_pulse[d]));
    chk($sformatf("d%0d.enc_count", d), encc, 32'(m_enc[d]));
    chk($sformatf("d%0d.err_count", d), errc, 32'(m_err[d]));
  endtask

  // One clock: model decides acceptance from pre-edge state, both advance
  // on the edge, then every output is compared 1 time unit later.
  task automatic cycle();
    logic [32:0] m;
    bit          acc [2];
    bit          pp  [2];
    m = model_encode(in_op, in_rd, in_f3, in_rs1, in_rs2, in_imm, in_type);
    for (int d = 0; d < 2; d++) begin
      acc[d] = in_valid && !rst && (exp_q[d].size() < depth[d]);
      pp[d]  = (exp_q[d].size() > 0) && out_ready;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_q[d].delete();
        m_enc[d] = 0;
        m_err[d] = 0;
        m_pulse[d] = 1'b0;
      end else begin
        if (pp[d]) void'(exp_q[d].pop_front());
        if (acc[d] && (!m[32] || !drop[d])) begin
          exp_q[d].push_back(m);
          if (m_enc[d] < cmax[d]) m_enc[d]++;
        end
        if (acc[d] && m[32] && (m_err[d] < cmax[d])) m_err[d]++;
        m_pulse[d] = acc[d] && m[32];
      end
    end
    #1;
    check_dut(0, if0.in_ready_o, if0.out_valid_o, if0.out_instr_o, if0.out_err_o,
              pulse0, 32'(enc0), 32'(errc0));
    check_dut(1, if1.in_ready_o, if1.out_valid_o, if1.out_instr_o, if1.out_err_o,
              pulse1, 32'(enc1), 32'(errc1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    imm_type_e   t;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic set_req(input vec_t v);
    in_op = v.op; in_rd = v.rd; in_f3 = v.f3; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_imm = v.imm; in_type = v.t;
  endtask

  task automatic fill_table();
    vt[0]  = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFFFFFF, IMM_I, 32'hFFF00093, 1'b0};
    vt[1]  = '{7'h23, 5'd7, 3'd2, 5'd1, 5'd2, 32'h00000008, IMM_S, 32'h0020A423, 1'b0};
    vt[2]  = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFFFFFC, IMM_B, 32'hFE000EE3, 1'b0};
    vt[3]  = '{7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h12345000, IMM_U, 32'h123452B7, 1'b0};
    vt[4]  = '{7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h00000800, IMM_J, 32'h001000EF, 1'b0};
    vt[5]  = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'h00000003, IMM_B, 32'h00000163, 1'b1};
    vt[6]  = '{7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'h00000800, IMM_I, 32'h80000013, 1'b1};
    vt[7]  = '{7'h13, 5'd3, 3'd0, 5'd4, 5'd9, 32'h000007FF, IMM_I, 32'h7FF20193, 1'b0};
    vt[8]  = '{7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 32'hFFFFF800, IMM_S, 32'h8020A023, 1'b0};
    vt[9]  = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFFFFFE, IMM_J, 32'hFFFFF06F, 1'b0};
    vt[10] = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 32'h00100000, IMM_J, 32'h8000006F, 1'b1};
    vt[11] = '{7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h12345001, IMM_U, 32'h123452B7, 1'b1};
    vt[12] = '{7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 32'h00000004, imm_type_e'(3'd6), 32'h00000000, 1'b1};
    vt[13] = '{7'h63, 5'd0, 3'd1, 5'd2, 5'd3, 32'h00000FFE, IMM_B, 32'h7E311FE3, 1'b0};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_f3 = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_type = IMM_I;
    fill_table();
    for (int d = 0; d < 2; d++) begin
      m_enc[d] = 0; m_err[d] = 0; m_pulse[d] = 1'b0;
    end

    // reset state
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // table vectors, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      set_req(vt[i]);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d.keep_valid", i), 32'(if1.out_valid_o), 32'd1);
      chk($sformatf("vec%0d.keep_instr", i), if1.out_instr_o, vt[i].exp_word);
      chk($sformatf("vec%0d.keep_err", i), 32'(if1.out_err_o), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d.drop_valid", i), 32'(if0.out_valid_o), 32'(!vt[i].exp_err));
      chk($sformatf("vec%0d.drop_pulse", i), 32'(pulse0), 32'(vt[i].exp_err));
      if (!vt[i].exp_err)
        chk($sformatf("vec%0d.drop_instr", i), if0.out_instr_o, vt[i].exp_word);
      if (i == 0) chk("addi.enc_count", 32'(enc0), 32'd1);
      if (i == 6) begin
        chk("drop2.err_count", 32'(errc0), 32'd2);
        chk("drop2.enc_count", 32'(enc0), 32'd5);
      end
      cycle();
    end

    // backpressure: drop instance fills after two accepts
    out_ready = 1'b0;
    set_req(vt[0]); in_valid = 1'b1; cycle();
    set_req(vt[1]); cycle();
    chk("bp.full_ready", 32'(if0.in_ready_o), 32'd0);
    set_req(vt[3]); cycle();
    chk("bp.hold_instr", if0.out_instr_o, vt[0].exp_word);
    out_ready = 1'b1; cycle();
    chk("bp.ready_back", 32'(if0.in_ready_o), 32'd1);
    chk("bp.order1", if0.out_instr_o, vt[1].exp_word);
    cycle();
    chk("bp.order2", if0.out_instr_o, vt[3].exp_word);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // reset while holding two entries
    out_ready = 1'b0;
    set_req(vt[0]); in_valid = 1'b1; cycle();
    set_req(vt[1]); cycle();
    in_valid = 1'b0;
    rst = 1'b1; cycle();
    rst = 1'b0; cycle();
    chk("rst.out_valid", 32'(if0.out_valid_o), 32'd0);
    chk("rst.enc_count", 32'(enc0), 32'd0);
    chk("rst.err_count", 32'(errc0), 32'd0);
    chk("rst.in_ready", 32'(if0.in_ready_o), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // counter saturation on the 3-bit instance
    set_req(vt[0]); in_valid = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    in_valid = 1'b0;
    chk("sat.keep_enc", 32'(enc1), 32'd7);
    chk("sat.drop_enc", 32'(enc0), 32'd10);
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_op  = 7'($urandom); in_rd = 5'($urandom); in_f3 = 3'($urandom);
      in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_type = imm_type_e'(3'($urandom_range(0, 7)));
      case ($urandom_range(0, 3))
        0: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: in_imm = $urandom;
        2: in_imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        default: in_imm = 32'($urandom_range(0, 1048575)) << 12;
      endcase
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
